// File: rtl/mem_map_pkg.sv
// mem_map_pkg: data bus address map, timer control layout and prescaler helper
package mem_map_pkg;
  localparam logic [7:0] IO_BASE    = 8'hF0;
  localparam logic [7:0] GPIO_OUT_A = 8'hF0;
  localparam logic [7:0] GPIO_IN_A  = 8'hF1;
  localparam logic [7:0] TMR_CTRL_A = 8'hF2;
  localparam logic [7:0] TMR_CMP_A  = 8'hF3;
  localparam logic [7:0] TMR_CNT_A  = 8'hF4;
  localparam logic [7:0] TMR_STAT_A = 8'hF5;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_PS_LSB = 2;
  localparam int CTRL_IE     = 4;
  typedef struct packed {
    logic [2:0] rsvd;
    logic       ie;
    logic [1:0] ps;
    logic       auto_rl;
    logic       en;
  } tmr_ctrl_t;
  function automatic logic [5:0] ps_mask(input logic [1:0] ps);
    return ps == 2'd0 ? 6'h00 : ps == 2'd1 ? 6'h03 : ps == 2'd2 ? 6'h0F : 6'h3F;
  endfunction
endpackage

// File: rtl/bus_timer.sv
// bus_timer: 8-bit prescaled compare timer with match flag and irq
module bus_timer
  import mem_map_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wdata,
  input  logic       we_ctrl,
  input  logic       we_cmp,
  input  logic       we_cnt,
  input  logic       we_stat,
  output logic [7:0] ctrl_rd,
  output logic [7:0] cmp_rd,
  output logic [7:0] cnt_rd,
  output logic [7:0] stat_rd,
  output logic       irq
);
  tmr_ctrl_t  ctrl;
  logic [7:0] cmp, cnt;
  logic [5:0] pre;
  logic       flag, tick, match;
  always_comb begin
    tick  = ctrl[CTRL_EN] && ((pre | ~ps_mask(ctrl[CTRL_PS_LSB +: 2])) == 6'h3F);
    match = tick && cnt == cmp;
  end
  // CPU writes override timer events; a new match outranks a same-cycle W1C
  always_ff @(posedge clk)
    if (!reset) begin
      ctrl <= '0;
      cmp  <= 8'hFF;
      cnt  <= 8'h00;
      flag <= 1'b0;
      pre  <= 6'd0;
    end else begin
      pre  <= (we_ctrl || we_cnt || !ctrl[CTRL_EN]) ? 6'd0 : pre + 6'd1;
      cmp  <= we_cmp ? wdata : cmp;
      cnt  <= we_cnt ? wdata : !tick ? cnt : !match ? cnt + 8'd1 : ctrl[CTRL_AUTO] ? 8'd0 : cnt;
      flag <= match || (flag && !(we_stat && wdata[0]));
      if (we_ctrl) ctrl <= {3'b000, wdata[4:0]};
      else if (match && !ctrl[CTRL_AUTO]) ctrl[CTRL_EN] <= 1'b0;
    end
  assign ctrl_rd = ctrl;
  assign cmp_rd  = cmp;
  assign cnt_rd  = cnt;
  assign stat_rd = {7'd0, flag};
  assign irq     = flag && ctrl[CTRL_IE];
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: single-cycle CPU data bus slave with RAM, GPIO and timer page
module mem_bus_responder #(
  parameter int         RAM_DEPTH   = 240,
  parameter logic [7:0] IO_BASE     = mem_map_pkg::IO_BASE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Address,
  input  logic [7:0] WriteData,
  input  logic       MemWrite_Enable,
  output logic [7:0] ReadData,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       timer_irq
);
  import mem_map_pkg::*;
  logic [7:0] ram [RAM_DEPTH];
  logic [SYNC_STAGES-1:0][7:0] sync;
  logic [7:0] ctrl_rd, cmp_rd, cnt_rd, stat_rd;
  logic is_ram;
  assign is_ram = Address < IO_BASE;
  // RAM has no reset, but reset still blocks stores
  always_ff @(posedge clk)
    if (reset && MemWrite_Enable && is_ram) ram[Address] <= WriteData;
  always_ff @(posedge clk)
    if (!reset) begin
      gpio_out <= 8'h00;
      sync     <= '0;
    end else begin
      if (MemWrite_Enable && Address == GPIO_OUT_A) gpio_out <= WriteData;
      sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  bus_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wdata   (WriteData),
    .we_ctrl (MemWrite_Enable && Address == TMR_CTRL_A),
    .we_cmp  (MemWrite_Enable && Address == TMR_CMP_A),
    .we_cnt  (MemWrite_Enable && Address == TMR_CNT_A),
    .we_stat (MemWrite_Enable && Address == TMR_STAT_A),
    .ctrl_rd (ctrl_rd),
    .cmp_rd  (cmp_rd),
    .cnt_rd  (cnt_rd),
    .stat_rd (stat_rd),
    .irq     (timer_irq)
  );
  always_comb
    ReadData = is_ram                 ? ram[Address]
             : Address == GPIO_OUT_A ? gpio_out
             : Address == GPIO_IN_A  ? sync[SYNC_STAGES-1]
             : Address == TMR_CTRL_A ? ctrl_rd
             : Address == TMR_CMP_A  ? cmp_rd
             : Address == TMR_CNT_A  ? cnt_rd
             : Address == TMR_STAT_A ? stat_rd
             : 8'h00;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: vector table, directed timer corners and randomized model comparison
module tb_mem_bus_responder;
  localparam int SYNC = 2;
  logic       clk = 1'b0, reset = 1'b0, MemWrite_Enable = 1'b0, timer_irq;
  logic [7:0] Address = 8'h00, WriteData = 8'h00, gpio_in = 8'h00, ReadData, gpio_out;
  int total = 0, bad = 0;

  mem_bus_responder dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite_Enable(MemWrite_Enable), .ReadData(ReadData), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;

  // reference model: register file as plain variables, sync chain as a queue
  logic [7:0] m_ram [256];
  logic [7:0] m_gpio, m_ctrl, m_cmp, m_cnt;
  logic       m_flag;
  int         m_pre;
  logic [7:0] m_sync [$];

  task automatic model_edge(input logic rst_n, input logic [7:0] a, input logic [7:0] wd, input logic we, input logic [7:0] gin);
    int period;
    logic tick, hit;
    logic [7:0] n_ctrl, n_cnt;
    logic n_flag;
    int n_pre;
    if (!rst_n) begin
      m_gpio = 8'h00; m_ctrl = 8'h00; m_cmp = 8'hFF; m_cnt = 8'h00; m_flag = 1'b0; m_pre = 0;
      m_sync = {};
      for (int i = 0; i < SYNC; i++) m_sync.push_back(8'h00);
      return;
    end
    period = 1 << (2 * m_ctrl[3:2]);
    tick = m_ctrl[0] && (m_pre % period == period - 1);
    hit = tick && (m_cnt == m_cmp);
    n_ctrl = m_ctrl; n_cnt = m_cnt; n_flag = m_flag;
    n_pre = m_ctrl[0] ? (m_pre + 1) % 64 : 0;
    if (tick) begin
      if (hit) begin
        n_flag = 1'b1;
        if (m_ctrl[1]) n_cnt = 8'h00; else n_ctrl[0] = 1'b0;
      end else n_cnt = 8'((int'(m_cnt) + 1) % 256);
    end
    if (we) begin
      if (a < 8'hF0) m_ram[a] = wd;
      else case (a)
        8'hF0: m_gpio = wd;
        8'hF2: begin n_ctrl = wd & 8'h1F; n_pre = 0; end
        8'hF3: m_cmp = wd;
        8'hF4: begin n_cnt = wd; n_pre = 0; end
        8'hF5: if (wd[0] && !hit) n_flag = 1'b0;
        default: ;
      endcase
    end
    m_ctrl = n_ctrl; m_cnt = n_cnt; m_flag = n_flag; m_pre = n_pre;
    m_sync.push_front(gin);
    void'(m_sync.pop_back());
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a < 8'hF0) return m_ram[a];
    case (a)
      8'hF0: return m_gpio;
      8'hF1: return m_sync[m_sync.size() - 1];
      8'hF2: return m_ctrl;
      8'hF3: return m_cmp;
      8'hF4: return m_cnt;
      8'hF5: return {7'd0, m_flag};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // one bus cycle; inputs held across the edge, outputs sampled 1 unit later
  task automatic step(input logic [7:0] a, input logic [7:0] wd, input logic we);
    Address = a; WriteData = wd; MemWrite_Enable = we;
    @(posedge clk);
    model_edge(reset, a, wd, we, gpio_in);
    #1;
    MemWrite_Enable = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    Address = a;
    #1;
    d = ReadData;
  endtask

  typedef struct {
    logic       we;
    logic [7:0] a, wd, rd, gpio;
    logic       irq;
  } vec_t;
  vec_t vt [16];

  initial begin
    logic [7:0] d;
    logic [7:0] exp_b [4];
    logic       irq_b [4];
    int         r;
    logic [7:0] a, wd;
    logic       we;
    vt[0]  = '{1'b1, 8'h10, 8'hA5, 8'hA5, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 8'hF3, 8'h00, 8'hFF, 8'h00, 1'b0};
    vt[3]  = '{1'b0, 8'hF2, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[4]  = '{1'b1, 8'hF0, 8'h3C, 8'h3C, 8'h3C, 1'b0};
    vt[5]  = '{1'b1, 8'hF8, 8'h77, 8'h00, 8'h3C, 1'b0};
    vt[6]  = '{1'b0, 8'hF8, 8'h00, 8'h00, 8'h3C, 1'b0};
    vt[7]  = '{1'b1, 8'hF2, 8'hF0, 8'h10, 8'h3C, 1'b0};
    vt[8]  = '{1'b1, 8'hF5, 8'hFF, 8'h00, 8'h3C, 1'b0};
    vt[9]  = '{1'b1, 8'hF1, 8'h55, 8'h00, 8'h3C, 1'b0};
    vt[10] = '{1'b1, 8'hEF, 8'h5A, 8'h5A, 8'h3C, 1'b0};
    vt[11] = '{1'b1, 8'h00, 8'h11, 8'h11, 8'h3C, 1'b0};
    vt[12] = '{1'b1, 8'hF3, 8'h07, 8'h07, 8'h3C, 1'b0};
    vt[13] = '{1'b1, 8'hF4, 8'h09, 8'h09, 8'h3C, 1'b0};
    vt[14] = '{1'b0, 8'hF4, 8'h00, 8'h09, 8'h3C, 1'b0};
    vt[15] = '{1'b1, 8'hF2, 8'h00, 8'h00, 8'h3C, 1'b0};

    step(8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    check("rst gpio_out", gpio_out, 8'h00);
    check("rst irq", {7'd0, timer_irq}, 8'h00);
    peek(8'hF3, d); check("rst cmp", d, 8'hFF);
    peek(8'hF4, d); check("rst cnt", d, 8'h00);
    peek(8'hF2, d); check("rst ctrl", d, 8'h00);
    peek(8'hF5, d); check("rst stat", d, 8'h00);

    for (int i = 0; i < 240; i++) step(8'(i), 8'(i) ^ 8'h5A, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(vt[i].a, vt[i].wd, vt[i].we);
      check($sformatf("vec%0d rd", i), ReadData, vt[i].rd);
      check($sformatf("vec%0d gpio", i), gpio_out, vt[i].gpio);
      check($sformatf("vec%0d irq", i), {7'd0, timer_irq}, {7'd0, vt[i].irq});
    end

    gpio_in = 8'h81;
    step(8'hF1, 8'h00, 1'b0); check("sync 1 edge", ReadData, 8'h00);
    step(8'hF1, 8'h00, 1'b0); check("sync 2 edges", ReadData, 8'h81);

    exp_b = '{8'h01, 8'h02, 8'h03, 8'h00};
    irq_b = '{1'b0, 1'b0, 1'b0, 1'b1};
    step(8'hF3, 8'h03, 1'b1); step(8'hF4, 8'h00, 1'b1); step(8'hF2, 8'h13, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(8'hF4, 8'h00, 1'b0);
      check($sformatf("auto cnt%0d", k), ReadData, exp_b[k]);
      check($sformatf("auto irq%0d", k), {7'd0, timer_irq}, {7'd0, irq_b[k]});
    end
    step(8'hF5, 8'h01, 1'b1);
    check("w1c stat", ReadData, 8'h00);
    check("w1c irq", {7'd0, timer_irq}, 8'h00);
    step(8'hF2, 8'h00, 1'b1);

    step(8'hF3, 8'h02, 1'b1); step(8'hF4, 8'h00, 1'b1); step(8'hF2, 8'h05, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(8'hF4, 8'h00, 1'b0);
      check($sformatf("oneshot cnt%0d", k), ReadData, k < 4 ? 8'h00 : k < 8 ? 8'h01 : 8'h02);
      if (k == 11) begin peek(8'hF2, d); check("oneshot ctrl pre", d, 8'h05); end
      if (k == 12) begin
        peek(8'hF2, d); check("oneshot ctrl stop", d, 8'h04);
        peek(8'hF5, d); check("oneshot flag", d, 8'h01);
      end
    end
    step(8'hF5, 8'h01, 1'b1); step(8'hF2, 8'h00, 1'b1);

    step(8'hF3, 8'h05, 1'b1); step(8'hF4, 8'h04, 1'b1); step(8'hF2, 8'h13, 1'b1);
    step(8'hF4, 8'h40, 1'b1);
    check("cnt write wins", ReadData, 8'h40);
    peek(8'hF5, d); check("cnt write no flag", d, 8'h00);
    step(8'hF2, 8'h00, 1'b1);

    step(8'hF3, 8'h02, 1'b1); step(8'hF4, 8'h00, 1'b1); step(8'hF2, 8'h13, 1'b1);
    step(8'hF4, 8'h00, 1'b0); step(8'hF4, 8'h00, 1'b0);
    step(8'hF5, 8'h01, 1'b1);
    check("set beats w1c", ReadData, 8'h01);
    check("set beats w1c irq", {7'd0, timer_irq}, 8'h01);
    peek(8'hF4, d); check("reload on match", d, 8'h00);
    step(8'hF5, 8'h01, 1'b1);
    check("late w1c", ReadData, 8'h00);
    step(8'hF2, 8'h00, 1'b1);

    step(8'hF3, 8'h02, 1'b1); step(8'hF4, 8'h02, 1'b1); step(8'hF2, 8'h01, 1'b1);
    step(8'hF2, 8'h03, 1'b1);
    check("ctrl write beats stop", ReadData, 8'h03);
    step(8'hF2, 8'h00, 1'b1); step(8'hF5, 8'h01, 1'b1);

    step(8'hF0, 8'hE7, 1'b1); step(8'hF3, 8'h01, 1'b1); step(8'hF4, 8'h00, 1'b1); step(8'hF2, 8'h13, 1'b1);
    repeat (3) step(8'hF4, 8'h00, 1'b0);
    check("run irq", {7'd0, timer_irq}, 8'h01);
    reset = 1'b0;
    step(8'hF0, 8'hEE, 1'b1);
    reset = 1'b1;
    check("mid rst gpio", gpio_out, 8'h00);
    check("mid rst irq", {7'd0, timer_irq}, 8'h00);
    peek(8'hF2, d); check("mid rst ctrl", d, 8'h00);
    peek(8'hF3, d); check("mid rst cmp", d, 8'hFF);
    peek(8'hF4, d); check("mid rst cnt", d, 8'h00);
    peek(8'hF5, d); check("mid rst stat", d, 8'h00);
    peek(8'hF1, d); check("mid rst sync", d, 8'h00);
    peek(8'h10, d); check("ram kept", d, 8'hA5);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      a = r < 4 ? 8'($urandom_range(0, 239)) : 8'($urandom_range(240, 255));
      we = $urandom_range(0, 2) == 0;
      wd = (a == 8'hF3 || a == 8'hF4) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
      reset = $urandom_range(0, 399) != 0;
      step(a, wd, we);
      reset = 1'b1;
      check($sformatf("rnd%0d rd@%02h", n, a), ReadData, m_read(a));
      check($sformatf("rnd%0d gpio", n), gpio_out, m_gpio);
      check($sformatf("rnd%0d irq", n), {7'd0, timer_irq}, {7'd0, m_flag && m_ctrl[4]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Responder end of the CPU data bus: accepts Address/WriteData/MemWrite_Enable from the datapath and returns ReadData.
- Decodes an 8-bit address space into a data RAM window plus a memory-mapped I/O page (GPIO and one 8-bit timer).
- Sits between the datapath bus pins and the board pins.
- Serves a single-cycle CPU: reads are combinational, writes commit on the clock edge.

Parameters:
- RAM_DEPTH, 240: RAM bytes, mapped from 0x00 to RAM_DEPTH-1.
- IO_BASE, 8'hF0: base address of the I/O page; must equal RAM_DEPTH.
- SYNC_STAGES, 2: flop stages on gpio_in.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous active-low reset
- Address  in  8  byte address from datapath
- WriteData  in  8  store data from datapath
- MemWrite_Enable  in  1  1 = write this cycle
- ReadData  out  8  load data to datapath, combinational from Address
- gpio_in  in  8  asynchronous board inputs
- gpio_out  out  8  board outputs (GPIO_OUT register)
- timer_irq  out  1  match flag AND irq enable

Behaviour:
- Reset: one clock edge with reset low. Clears GPIO_OUT to 0x00, TMR_CTRL to 0x00, TMR_CNT to 0x00, TMR_CMP to 0xFF, flag to 0, prescaler to 0, and sync flops to 0. RAM is not cleared. After reset, gpio_out=0x00 and timer_irq=0.
- Reset mid-operation has priority over every write and every timer event.
- Address decode: Address < IO_BASE selects RAM. 0xF0-0xF5 select registers. 0xF6-0xFF read 0x00 and ignore writes.
- RAM: asynchronous read. Write at the clock edge when MemWrite_Enable=1.
- 0xF0 GPIO_OUT: RW.
- 0xF1 GPIO_IN: RO. Returns the last sync stage. Latency is SYNC_STAGES edges from a pin change.
- 0xF2 TMR_CTRL: RW.
  - bit0 EN.
  - bit1 AUTO: 1 = reload to 0 on match; 0 = one-shot.
  - bits3:2 PS: tick every 1/4/16/64 cycles.
  - bit4 IE.
  - bits7:5 read 0.
- 0xF3 TMR_CMP: RW.
- 0xF4 TMR_CNT: RW. A write loads the counter and clears the prescaler.
- 0xF5 TMR_STAT: bit0 is the match flag, write-1-to-clear. Other bits read 0.
- Prescaler: 6-bit counter.
  - Counts while EN=1. Held at 0 while EN=0.
  - Cleared on any write to TMR_CTRL or TMR_CNT.
  - Tick is asserted when the low 0/2/4/6 bits are all ones (PS=00 gives a tick every enabled cycle).
- Timer on tick:
  - If CNT==CMP: set flag. If AUTO=1, CNT<=0. Otherwise CNT holds and EN<=0 (one-shot stop).
  - Else: CNT<=CNT+1, wrapping 0xFF to 0x00 (only reachable after CMP is lowered below CNT).
- Simultaneous events:
  - CPU write to TMR_CNT beats increment/reload.
  - CPU write to TMR_CTRL beats one-shot EN clear.
  - Flag set beats W1C clear in the same cycle.
- No read side effects: reads may repeat freely, because the CPU holds Address combinationally.
- timer_irq is registered-flag based and changes only at clock edges.

Decomposition:
- Package mem_map_pkg holds:
  - address constants IO_BASE, GPIO_OUT_A, GPIO_IN_A, TMR_CTRL_A, TMR_CMP_A, TMR_CNT_A, TMR_STAT_A;
  - bit-position constants for CTRL (EN, AUTO, PS_LSB, IE);
  - a typedef for the packed CTRL struct.
- One sub-module, bus_timer, holds the prescaler, CNT, CMP, CTRL, flag and the irq logic. It takes decoded write strobes plus WriteData and returns its register read values.
- Top level holds the RAM array, GPIO, the synchronizer, and the decode/read mux.

Test Plan:
- Reset low one edge, then write 0xA5 to 0x10 and read 0x10. Expected: ReadData=0xA5, gpio_out=0x00, timer_irq=0. Read 0xF3 gives 0xFF.
- Write 0x3C to 0xF0. Expected: gpio_out=0x3C from the next edge. Drive gpio_in=0x81. Expected: read 0xF1 returns 0x00 for the first 1 edge and 0x81 after 2 edges.
- CMP=3, CTRL=0x13 (EN, AUTO, IE, PS=00). Expected: CNT steps 1,2,3,0 each cycle; flag and timer_irq rise on the edge where 3 reloads to 0. Write 0x01 to 0xF5. Expected: flag cleared next edge.
- CMP=2, CTRL=0x05 (EN, one-shot, PS=01). Expected: CNT increments every 4 cycles. At the 12th tick-cycle it reaches 2, then on match EN reads 0 and CNT holds at 2.
- With CNT at CMP-1 (AUTO on), write 0x40 to 0xF4 in the same cycle a tick is due. Expected: CNT=0x40, no flag. Separately, issue a W1C on the match edge. Expected: flag remains 1.
- Write 0x77 to 0xF8 and read 0xF8. Expected: 0x00. Also assert reset during an active timer run. Expected: all registers return to reset values next edge.
